// File: rtl/lcd_init_sequencer.sv
// Walks a command table held in a synchronous ROM and replays it as AXI4-Lite
// register writes and timed waits to bring up the LCD controller.
module lcd_init_sequencer #(
    parameter logic [31:0] C_BASE_ADDR = 32'h43C0_0000,
    parameter int unsigned C_TBL_DEPTH = 16,
    parameter int unsigned C_TBL_AW    = 4
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                INIT_START,
    output logic                SEQ_BUSY,
    output logic                SEQ_DONE,
    output logic                SEQ_ERROR,
    output logic [C_TBL_AW-1:0] TBL_ADDR,
    input  logic [41:0]         TBL_DATA,
    output logic [31:0]         M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [31:0]         M_AXI_WDATA,
    output logic [3:0]          M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StWrite  = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;
    localparam logic [2:0] StWait   = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    localparam logic [C_TBL_AW-1:0] LastIdx = C_TBL_AW'(C_TBL_DEPTH - 1);

    logic [2:0]          state_q, state_d;
    logic [C_TBL_AW-1:0] index_q, index_d;
    logic [31:0]         count_q, count_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                error_q, error_d;
    logic                start_hist_q;
    logic                armed_q;
    logic                start;
    logic                advance;
    logic                aw_clear;
    logic                w_clear;

    // armed_q blocks a level held high across reset release from looking like an edge
    assign start    = INIT_START & ~start_hist_q & armed_q;
    // a low valid while in StWrite means that channel has already handshaken
    assign aw_clear = ~awvalid_q | M_AXI_AWREADY;
    assign w_clear  = ~wvalid_q | M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        error_d   = error_q;
        advance   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFetch;
                    index_d = '0;
                    error_d = 1'b0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                case (TBL_DATA[41:40])
                    2'b00: begin
                        awaddr_d  = C_BASE_ADDR + {24'h0, TBL_DATA[39:32]};
                        wdata_d   = TBL_DATA[31:0];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrite;
                    end
                    2'b01: begin
                        count_d = TBL_DATA[31:0];
                        state_d = StWait;
                    end
                    2'b10: state_d = StDone;
                    default: begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                endcase
            end
            StWrite: begin
                if (aw_clear && w_clear) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP[1]) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StWait: begin
                if (count_q == 32'd0) begin
                    advance = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // the table ends at its last entry; the index never wraps
        if (advance) begin
            if (index_q == LastIdx) begin
                state_d = StDone;
            end else begin
                index_d = index_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            index_q      <= '0;
            count_q      <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            error_q      <= 1'b0;
            start_hist_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            count_q      <= count_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            error_q      <= error_d;
            start_hist_q <= INIT_START;
            armed_q      <= 1'b1;
        end
    end

    assign TBL_ADDR      = index_q;
    assign SEQ_BUSY      = (state_q != StIdle) && (state_q != StDone);
    assign SEQ_DONE      = (state_q == StDone);
    assign SEQ_ERROR     = error_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == StResp);

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: ROM model, configurable AXI4-Lite slave and a
// table-walking reference model that predicts the write stream and flags.
module tb_lcd_init_sequencer;

    localparam logic [31:0] BASE = 32'h43C0_0000;

    logic        tb_ACLK = 1'b0;
    logic        rstn;
    logic        init_start;
    logic        busy, done, error;
    logic [3:0]  tbl_addr;
    logic [41:0] tbl_data;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;

    always #5 tb_ACLK = ~tb_ACLK;

    lcd_init_sequencer #(
        .C_BASE_ADDR (BASE),
        .C_TBL_DEPTH (16),
        .C_TBL_AW    (4)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (rstn),
        .INIT_START    (init_start),
        .SEQ_BUSY      (busy),
        .SEQ_DONE      (done),
        .SEQ_ERROR     (error),
        .TBL_ADDR      (tbl_addr),
        .TBL_DATA      (tbl_data),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    // Command table ROM, one-cycle read latency
    logic [41:0] tbl [16];
    always @(posedge tb_ACLK) tbl_data <= tbl[tbl_addr];

    // AXI4-Lite slave: per-channel ready delays, B delay and a per-write response plan
    int         aw_dly = 0, w_dly = 0, b_dly = 0;
    int         aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic       aw_got = 1'b0, w_got = 1'b0;
    logic [1:0] bresp_plan [16];
    int         nb_total = 0;
    int         nb_base = 0;
    int         b_idx;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign b_idx   = nb_total - nb_base;

    always @(posedge tb_ACLK) begin
        if (!rstn) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
        end
    end

    always @(posedge tb_ACLK) begin
        if (!rstn) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            b_cnt  <= 0;
        end else begin
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready) w_got <= 1'b1;
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_cnt  <= 0;
            end else if (!bvalid && aw_got && w_got) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1'b1;
                    bresp  <= bresp_plan[b_idx[3:0]];
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    // Bus monitor: records accepted writes and protocol statistics
    logic [31:0] act_addr [$];
    logic [31:0] act_data [$];
    int          aw_hi = 0, w_hi = 0, ost = 0, overlap = 0, unstable = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] aw_prev = '0, w_prev = '0;

    always @(posedge tb_ACLK) begin
        if (!rstn) begin
            ost     <= 0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid) w_hi <= w_hi + 1;
            if (awvalid && awready) act_addr.push_back(awaddr);
            if (wvalid && wready) act_data.push_back(wdata);
            if (bvalid && bready) nb_total <= nb_total + 1;
            if (awvalid && awready && ost != 0) overlap <= overlap + 1;
            ost <= ost + ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
            if ((aw_pend && (!awvalid || awaddr != aw_prev)) ||
                (w_pend && (!wvalid || wdata != w_prev))) begin
                unstable <= unstable + 1;
            end
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
            aw_prev <= awaddr;
            w_prev  <= wdata;
        end
    end

    int total = 0;
    int bad = 0;
    int wr_base = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the table by its rules, stop at END/reserved/error response
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    function automatic void model(output bit err, output int busy_w);
        int         nw;
        logic [1:0] op;
        exp_addr.delete();
        exp_data.delete();
        err    = 1'b0;
        busy_w = 0;
        nw     = 0;
        for (int i = 0; i < 16; i++) begin
            op = tbl[i][41:40];
            busy_w += 2;
            if (op == 2'b00) begin
                exp_addr.push_back(BASE + {24'h0, tbl[i][39:32]});
                exp_data.push_back(tbl[i][31:0]);
                if (bresp_plan[nw][1]) begin
                    err = 1'b1;
                    break;
                end
                nw++;
            end else if (op == 2'b01) begin
                busy_w += int'(tbl[i][31:0]) + 1;
            end else begin
                err = (op == 2'b11);
                break;
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge tb_ACLK);
        rstn = 1'b0;
        repeat (2) @(negedge tb_ACLK);
        rstn = 1'b1;
        @(negedge tb_ACLK);
    endtask

    task automatic fill_tbl_end();
        for (int i = 0; i < 16; i++) tbl[i] = {2'b10, 8'h00, 32'h0};
        for (int i = 0; i < 16; i++) bresp_plan[i] = 2'b00;
    endtask

    task automatic run_seq(input int budget, output int busy_n, output int first_aw,
                           output logic [2:0] k1);
        busy_n   = 0;
        first_aw = -1;
        k1       = '0;
        nb_base  = nb_total;
        wr_base  = act_addr.size();
        @(negedge tb_ACLK);
        init_start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge tb_ACLK);
            init_start = 1'b0;
            if (k == 1) k1 = {busy, done, error};
            if (busy) busy_n++;
            if (first_aw < 0 && awvalid) first_aw = k;
            if (done) break;
        end
        chk("seq_reaches_done", done, 1'b1);
    endtask

    task automatic check_run(input string tag, input bit exp_err);
        int n_a, n_d;
        n_a = act_addr.size() - wr_base;
        n_d = act_data.size() - wr_base;
        chk({tag, "_nwr_addr"}, n_a, exp_addr.size());
        chk({tag, "_nwr_data"}, n_d, exp_data.size());
        if (n_a == exp_addr.size() && n_d == exp_data.size()) begin
            for (int i = 0; i < n_a; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), act_addr[wr_base + i], exp_addr[i]);
                chk($sformatf("%s_data%0d", tag, i), act_data[wr_base + i], exp_data[i]);
            end
        end
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        bit         m_err;
        int         m_busy, busy_n, first_aw, a0, w0, nb0, base0;
        logic [2:0] k1;

        rstn       = 1'b0;
        init_start = 1'b0;
        fill_tbl_end();
        apply_reset();

        // Reset state
        chk("rst_flags", {busy, done, error}, 3'b000);
        chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("rst_tbl_addr", tbl_addr, 4'h0);
        chk("rst_awaddr_wdata", {awaddr, wdata}, 64'h0);
        chk("rst_prot_strb", {awprot, wstrb}, 7'h0F);

        // Single write then END, slave always ready
        tbl[0] = {2'b00, 8'h04, 32'h0000_00A5};
        model(m_err, m_busy);
        run_seq(200, busy_n, first_aw, k1);
        chk("t1_start_flags", k1, 3'b100);
        chk("t1_aw_latency", first_aw, 3);
        check_run("t1", m_err);

        // AWREADY delayed by 3 cycles, WREADY immediate
        apply_reset();
        aw_dly = 3;
        a0 = aw_hi; w0 = w_hi; nb0 = nb_total;
        model(m_err, m_busy);
        run_seq(200, busy_n, first_aw, k1);
        chk("t2_aw_high_cycles", aw_hi - a0, 4);
        chk("t2_w_high_cycles", w_hi - w0, 1);
        chk("t2_b_handshakes", nb_total - nb0, 1);
        check_run("t2", m_err);
        aw_dly = 0;

        // WAIT of 9 followed by END: 10 wait cycles inside 14 busy cycles
        apply_reset();
        fill_tbl_end();
        tbl[0] = {2'b01, 8'h00, 32'h0000_0009};
        model(m_err, m_busy);
        run_seq(200, busy_n, first_aw, k1);
        chk("t3_busy_cycles", busy_n, m_busy);
        chk("t3_no_write", first_aw, -1);
        check_run("t3", m_err);

        // Error response on second write aborts; restart clears the flags
        apply_reset();
        fill_tbl_end();
        for (int i = 0; i < 3; i++) tbl[i] = {2'b00, 8'(8'h20 + 4 * i), 32'(32'h100 + i)};
        bresp_plan[1] = 2'b10;
        model(m_err, m_busy);
        run_seq(300, busy_n, first_aw, k1);
        check_run("t4", m_err);
        bresp_plan[1] = 2'b00;
        model(m_err, m_busy);
        run_seq(300, busy_n, first_aw, k1);
        chk("t4_restart_flags", k1, 3'b100);
        check_run("t4r", m_err);

        // 16 writes, no END: stops after index 15 without wrapping
        apply_reset();
        for (int i = 0; i < 16; i++) tbl[i] = {2'b00, 8'(4 * i), $urandom()};
        model(m_err, m_busy);
        run_seq(1000, busy_n, first_aw, k1);
        check_run("t5", m_err);
        chk("t5_tbl_addr_end", tbl_addr, 4'hF);
        repeat (3) @(negedge tb_ACLK);
        chk("t5_tbl_addr_hold", {tbl_addr, done}, 5'h1F);

        // INIT_START held high through reset release must not start
        base0 = act_addr.size();
        @(negedge tb_ACLK);
        init_start = 1'b1;
        apply_reset();
        repeat (5) @(negedge tb_ACLK);
        chk("t6_no_start_busy", {busy, done}, 2'b00);
        chk("t6_no_writes", act_addr.size() - base0, 0);
        init_start = 1'b0;
        @(negedge tb_ACLK);

        // Reset during RESP of write 2, then rerun from index 0
        fill_tbl_end();
        for (int i = 0; i < 3; i++) tbl[i] = {2'b00, 8'(8'h10 + 4 * i), 32'(32'hC0 + i)};
        b_dly = 4;
        nb_base = nb_total;
        wr_base = act_addr.size();
        @(negedge tb_ACLK);
        init_start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge tb_ACLK);
            init_start = 1'b0;
            if (bready && (nb_total - nb_base) == 1) break;
        end
        chk("t7_in_resp2", {bready, 32'(nb_total - nb_base)}, {1'b1, 32'd1});
        rstn = 1'b0;
        @(negedge tb_ACLK);
        chk("t7_rst_outs", {awvalid, wvalid, bready, busy, done, error, tbl_addr}, 10'h0);
        chk("t7_rst_bus", {awaddr, wdata}, 64'h0);
        rstn = 1'b1;
        repeat (3) @(negedge tb_ACLK);
        chk("t7_no_more_aw", act_addr.size() - wr_base, 2);
        model(m_err, m_busy);
        run_seq(400, busy_n, first_aw, k1);
        check_run("t7r", m_err);
        b_dly = 0;

        // Randomised tables, slave timing and responses
        for (int r = 0; r < 6; r++) begin
            int x;
            apply_reset();
            for (int i = 0; i < 16; i++) begin
                x = $urandom_range(0, 99);
                if (x < 60) tbl[i] = {2'b00, 8'($urandom()), $urandom()};
                else if (x < 85) tbl[i] = {2'b01, 8'($urandom()), 32'($urandom_range(0, 6))};
                else if (x < 95) tbl[i] = {2'b10, 8'($urandom()), $urandom()};
                else tbl[i] = {2'b11, 8'($urandom()), $urandom()};
                x = $urandom_range(0, 99);
                bresp_plan[i] = (x < 8) ? 2'b10 : ((x < 12) ? 2'b11 : 2'($urandom_range(0, 1)));
            end
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            model(m_err, m_busy);
            run_seq(3000, busy_n, first_aw, k1);
            check_run($sformatf("rnd%0d", r), m_err);
        end

        chk("one_outstanding_write", overlap, 0);
        chk("valid_payload_stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 SHALL have parameter C_BASE_ADDR, default 32'h43C0_0000, base byte address of the LCD IP AXI4-Lite slave.
REQ-002 SHALL have parameter C_TBL_DEPTH, default 16, number of command-table entries (power of 2, 2..256).
REQ-003 SHALL have parameter C_TBL_AW, default 4, table index width, equal to log2(C_TBL_DEPTH).
REQ-004 SHALL have ports: ACLK in 1 clock; ARESETN in 1 reset (one clock; reset is synchronous and active-low).
REQ-005 SHALL have ports: INIT_START in 1 sequence trigger (rising edge); SEQ_BUSY out 1; SEQ_DONE out 1; SEQ_ERROR out 1.
REQ-006 SHALL have ports: TBL_ADDR out C_TBL_AW table index; TBL_DATA in 42 entry {op[41:40], offset[39:32], value[31:0]}, valid one cycle after TBL_ADDR (synchronous ROM).
REQ-007 SHALL have ports: M_AXI_AWADDR out 32; M_AXI_AWPROT out 3 (tied 0); M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-008 SHALL have ports: M_AXI_WDATA out 32; M_AXI_WSTRB out 4 (tied 4'hF); M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-009 SHALL have ports: M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, DECODE, WRITE, RESP, WAIT, DONE.
REQ-011 SHALL detect start as INIT_START sampled 1 with previous-cycle sample 0; edges outside IDLE/DONE SHALL be ignored.
REQ-012 SHALL on start: clear SEQ_DONE and SEQ_ERROR, reset index to 0, set SEQ_BUSY, enter FETCH next cycle.
REQ-013 SHALL in FETCH drive TBL_ADDR=index; DECODE next cycle samples TBL_DATA.
REQ-014 SHALL decode op: 2'b00 WRITE, 2'b01 WAIT, 2'b10 END, 2'b11 reserved (END with SEQ_ERROR=1).
REQ-015 SHALL in WRITE present AWADDR=C_BASE_ADDR+{24'h0,offset}, WDATA=value, assert AWVALID and WVALID in the same cycle.
REQ-016 SHALL deassert AWVALID the cycle after AWVALID&AWREADY and WVALID the cycle after WVALID&WREADY, independently; address/data stable while valid.
REQ-017 SHALL enter RESP once both handshakes completed (same or different cycles); BREADY=1 only in RESP.
REQ-018 SHALL on BVALID&BREADY: BRESP[1]=1 -> SEQ_ERROR=1, go DONE (abort); else advance index.
REQ-019 SHALL in WAIT load counter=value in DECODE, decrement each WAIT cycle, exit when counter==0 (value N -> N+1 WAIT cycles; N=0 -> 1 cycle).
REQ-020 SHALL on advance: index==C_TBL_DEPTH-1 -> DONE (no wrap); else index+1 and FETCH.
REQ-021 SHALL in DONE hold SEQ_DONE=1, SEQ_BUSY=0 until next start; SEQ_ERROR sticky until next start.
REQ-022 SHALL SEQ_BUSY=1 in every state except IDLE and DONE.
REQ-023 SHALL latency: start edge sampled at cycle t -> FETCH t+1, DECODE t+2, AWVALID/WVALID high at t+3.
REQ-024 SHALL never issue a new AW before the previous B handshake (one outstanding write).

Reset
REQ-025 SHALL on ARESETN=0 at a clock edge: state IDLE, index 0, counter 0, AWVALID=WVALID=BREADY=0, SEQ_BUSY=SEQ_DONE=SEQ_ERROR=0, TBL_ADDR=0, start-edge history 0.
REQ-026 SHALL abandon any in-progress sequence on reset mid-operation with no further AXI activity; INIT_START held high through reset release SHALL not trigger a start.

Verification
REQ-027 Table {00,04,0000_00A5},{10,..}; slave always ready, OKAY -> one write AWADDR=43C0_0004, WDATA=A5, SEQ_DONE=1, SEQ_ERROR=0.
REQ-028 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single B handshake, no duplicate write.
REQ-029 Entry {01,00,0000_0009} then END -> exactly 10 WAIT cycles, SEQ_BUSY high throughout, then SEQ_DONE=1.
REQ-030 Second write gets BRESP=2'b10 -> SEQ_ERROR=1, SEQ_DONE=1, remaining entries not issued; new start clears both.
REQ-031 16 WRITE entries, no END -> 16 writes to offsets in order, DONE after index 15, TBL_ADDR never wraps to 0.
REQ-032 ARESETN low during RESP of write 2 -> all outputs 0 next cycle; start edge after release re-runs from index 0.
